// File: rtl/modn_counter_if.sv
// Control and status bundle for modn_counter_gen.
// MODN_WRAP_CNT_EN adds the 16-bit wraps status field.
interface modn_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [1:0]       mode;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             load_err;
`ifdef MODN_WRAP_CNT_EN
    logic [15:0]      wraps;

    modport master (
        output en, mode, up_dn, load, load_val,
        input  out, tc, load_err, wraps
    );
    modport slave (
        input  en, mode, up_dn, load, load_val,
        output out, tc, load_err, wraps
    );
`else
    modport master (
        output en, mode, up_dn, load, load_val,
        input  out, tc, load_err
    );
    modport slave (
        input  en, mode, up_dn, load, load_val,
        output out, tc, load_err
    );
`endif
endinterface

// File: rtl/modn_counter_gen.sv
// Modulo-N counter with up/down/external/bounce modes, clamped load and terminal count.
// Optional MODN_WRAP_CNT_EN adds a saturating count of terminal-count cycles.
//
// dir   | meaning
// DIR_UP | bounce mode is counting upward, turns at N-1
// DIR_DN | bounce mode is counting downward, turns at 0
module modn_counter_gen #(
    parameter int N     = 10,
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    modn_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(N - 1);
    localparam logic [WIDTH:0]   N_EXT   = (WIDTH + 1)'(N);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

    logic [WIDTH-1:0] out_q;
    dir_t             dir;
    logic             load_err_q;

    logic             up_active;
    logic             at_max;
    logic             at_zero;
    logic             in_range;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;
    logic [WIDTH-1:0] count_next;
    dir_t             dir_next;
    logic             tc_int;

    assign at_max   = (out_q == MAX_VAL);
    assign at_zero  = (out_q == '0);
    assign in_range = ({1'b0, bus.load_val} < N_EXT);

    // Explicit wrap keeps N = 2^WIDTH correct without relying on natural overflow
    assign inc_val = at_max  ? '0      : out_q + ONE;
    assign dec_val = at_zero ? MAX_VAL : out_q - ONE;

    always_comb begin
        up_active = 1'b1;
        case (bus.mode)
            2'b00:   up_active = 1'b1;
            2'b01:   up_active = 1'b0;
            2'b10:   up_active = bus.up_dn;
            default: up_active = (dir == DIR_UP);
        endcase
    end

    always_comb begin
        count_next = up_active ? inc_val : dec_val;
        dir_next   = dir;
        if (bus.mode == 2'b11) begin
            if (dir == DIR_UP && at_max) begin
                count_next = MAX_VAL - ONE;
                dir_next   = DIR_DN;
            end else if (dir == DIR_DN && at_zero) begin
                count_next = ONE;
                dir_next   = DIR_UP;
            end
        end
    end

    assign tc_int = !reset && bus.en && !bus.load &&
                    ((at_max && up_active) || (at_zero && !up_active));

`ifdef MODN_WRAP_CNT_EN
    logic [15:0] wraps_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q      <= '0;
            dir        <= DIR_UP;
            load_err_q <= 1'b0;
        end else if (bus.load) begin
            out_q      <= in_range ? bus.load_val : MAX_VAL;
            load_err_q <= !in_range;
        end else if (bus.en) begin
            out_q      <= count_next;
            dir        <= dir_next;
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= 1'b0;
        end
`ifdef MODN_WRAP_CNT_EN
        if (reset) begin
            wraps_q <= '0;
        end else if (tc_int && wraps_q != 16'hFFFF) begin
            wraps_q <= wraps_q + 16'd1;
        end
`endif
    end

    assign bus.out      = out_q;
    assign bus.tc       = tc_int;
    assign bus.load_err = load_err_q;
`ifdef MODN_WRAP_CNT_EN
    assign bus.wraps    = wraps_q;
`endif

endmodule

// File: doc/modn_counter_gen.md
MODN_COUNTER_GEN -- requirements
Module: modn_counter_gen

Interface
REQ-001 Parameter N, default 10: count modulus; legal range 2..2^WIDTH.
REQ-002 Parameter WIDTH, default 4: width of the count output and the load value.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 reset  input  1: synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 en  input  1: count enable; the count holds when low.
REQ-006 mode  input  2: count mode.
  - 00 UP
  - 01 DOWN
  - 10 EXT (up_dn selects the direction)
  - 11 BOUNCE (ping-pong)
REQ-007 up_dn  input  1: direction in EXT mode only; 1 = up, 0 = down; ignored in other modes.
REQ-008 load  input  1: synchronous load strobe.
REQ-009 load_val  input  WIDTH: value loaded when load = 1.
REQ-010 out  output  WIDTH: current count, registered.
REQ-011 tc  output  1: terminal-count indication, combinational from current state and inputs.
REQ-012 load_err  output  1: registered one-cycle pulse flagging an out-of-range load.

Function
REQ-013 Update priority each rising edge SHALL be: reset > load > en > hold.
REQ-014 Load SHALL give out <= load_val if load_val < N, else out <= N-1 with load_err = 1 on the next cycle only.
REQ-015 UP mode SHALL count out+1, wrapping N-1 -> 0.
REQ-016 DOWN mode SHALL count out-1, wrapping 0 -> N-1.
REQ-017 EXT mode SHALL behave as UP when up_dn = 1 and as DOWN when up_dn = 0.
REQ-018 BOUNCE mode SHALL use a direction register dir with states DIR_UP and DIR_DN.
  - DIR_UP: count +1; at out == N-1, next out = N-2 and dir -> DIR_DN.
  - DIR_DN: count -1; at out == 0, next out = 1 and dir -> DIR_UP.
REQ-019 dir SHALL change only in BOUNCE mode at a turn point with en = 1 and load = 0; load and other modes SHALL leave dir unchanged.
REQ-020 Active direction definition:
  - UP: up
  - DOWN: down
  - EXT: up_dn
  - BOUNCE: dir
REQ-021 tc SHALL be 1 exactly when all of the following hold:
  - en = 1, load = 0, reset = 0
  - either out == N-1 with active direction up, or out == 0 with active direction down
REQ-022 A mode change mid-count SHALL take effect on the next edge from the current out value, with no reset of out.
REQ-023 With en = 0 and load = 0, out, dir and load_err (cleared to 0) SHALL hold; tc = 0.
REQ-024 All next-count arithmetic SHALL be computed in WIDTH bits with explicit wrap; out SHALL never exceed N-1, including when N = 2^WIDTH.
REQ-025 With N = 2, BOUNCE SHALL alternate 0,1,0,1 with tc = 1 every enabled cycle.

Reset
REQ-026 reset = 1 SHALL force out = 0, dir = DIR_UP, load_err = 0 on the next edge, regardless of load and en.
REQ-027 During reset, tc SHALL be 0.
REQ-028 Reset asserted mid-count or mid-load SHALL discard the pending load; counting resumes from 0 on the first edge after reset deasserts.

Configuration
REQ-029 Macro MODN_WRAP_CNT_EN defined: add output wraps (output, 16 bits).
  - increments on every edge where tc = 1
  - saturates at 16'hFFFF
  - cleared only by reset; load does not clear it
REQ-030 Macro MODN_WRAP_CNT_EN undefined: the wraps port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (N = 10, WIDTH = 4)
REQ-031 Reset 2 cycles, mode = 00, en = 1 for 12 cycles -> out 0..9,0,1; tc high only in the cycle out == 9.
REQ-032 Reset, mode = 01, en = 1 -> out 0,9,8,...,0,9; tc high while out == 0.
REQ-033 load = 1, load_val = 12 -> out = 9 and load_err = 1 for one cycle; then load_val = 5 with en = 0 -> out = 5, load_err = 0.
REQ-034 mode = 11, en = 1 for 20 cycles from reset -> out 0..9,8..0,1; tc high at out = 9 (DIR_UP) and out = 0 (DIR_DN).
REQ-035 At out = 6, assert reset and load (load_val = 3) together -> out = 0 and dir = DIR_UP next cycle; out = 1 the cycle after reset releases.
REQ-036 With MODN_WRAP_CNT_EN defined, mode = 00, en = 1 for 25 cycles from reset -> wraps = 2; reset -> wraps = 0.
